concat_n_unit: RTL and testbench

//   N-way channel concatenation for HWC activations. Generalises the 2-input

---
 rtl/concat_n_unit_if.sv | 27 ++
 rtl/concat_n_unit.sv | 189 ++++++++++++++++++
 tb/tb_concat_n_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/concat_n_unit_if.sv
// Stream bundle for concat_n_unit: N_IN parallel input lanes and one output lane.
//   in_data/in_valid/in_ready : per-input streams, lane i = in_data[i*BUS_W +: BUS_W]
//   out_data/out_valid/out_ready/out_src/out_last : interleaved output stream
// slave is the unit's view; master is the view of the producer/consumer environment.
interface concat_n_unit_if #(
  parameter int unsigned BUS_W = 128,
  parameter int unsigned N_IN  = 4
);
  logic [N_IN*BUS_W-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [BUS_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_src;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src, out_last
  );
endinterface

// File: rtl/concat_n_unit.sv
// N-way per-pixel channel concatenation for HWC activations.
// For every pixel, forwards beats[0] beats from input 0, then beats[1] from input 1, and so on
// up to cfg_n_inputs-1; inputs with zero beats are skipped entirely.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_n_inputs/pixels/beats : job config, latched on an accepted start
//   start               : 1-cycle start pulse, honoured only when idle
//   busy/done/err_cfg   : job status; done pulses once per job or on a bad config
//   bus (slave)         : input lanes and registered output stream
module concat_n_unit #(
  parameter int unsigned BUS_W = 128,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cfg_n_inputs,
  input  logic [31:0]           cfg_pixels,
  input  logic [N_IN*CNT_W-1:0] cfg_beats,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  concat_n_unit_if.slave        bus
);

  localparam int unsigned SelW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [7:0]       n_q;
  logic [31:0]      pixels_q, pix_cnt_q;
  logic [CNT_W-1:0] beats_q [N_IN];
  logic [CNT_W-1:0] beat_cnt_q;
  logic [SelW-1:0]  sel_q;
  logic             busy_q, done_q, err_q;
  logic             out_valid_q, out_last_q;
  logic [BUS_W-1:0] out_data_q;
  logic [7:0]       out_src_q;

  logic [N_IN-1:0]  used_nz, cfg_nz, in_ready_c;
  logic [SelW-1:0]  first_idx, next_idx, cfg_first;
  logic             has_next, found_first, found_cfg;
  logic [BUS_W-1:0] sel_data;
  logic             sel_valid;
  logic [CNT_W-1:0] cur_beats;
  logic             xfer, beat_wrap, job_last, cfg_bad;

  // Lane selection helpers: lowest non-zero input, next non-zero input after sel_q.
  always_comb begin
    used_nz     = '0;
    cfg_nz      = '0;
    first_idx   = '0;
    next_idx    = '0;
    cfg_first   = '0;
    has_next    = 1'b0;
    found_first = 1'b0;
    found_cfg   = 1'b0;
    sel_data    = '0;
    sel_valid   = 1'b0;
    cur_beats   = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      used_nz[i] = (i < 32'(n_q)) && (beats_q[i] != '0);
      cfg_nz[i]  = (i < 32'(cfg_n_inputs)) && (cfg_beats[i*CNT_W +: CNT_W] != '0);
      if (sel_q == SelW'(i)) begin
        sel_data  = bus.in_data[i*BUS_W +: BUS_W];
        sel_valid = bus.in_valid[i];
        cur_beats = beats_q[i];
      end
      if (used_nz[i] && !found_first) begin
        first_idx   = SelW'(i);
        found_first = 1'b1;
      end
      if (cfg_nz[i] && !found_cfg) begin
        cfg_first = SelW'(i);
        found_cfg = 1'b1;
      end
      if (used_nz[i] && (i > 32'(sel_q)) && !has_next) begin
        next_idx = SelW'(i);
        has_next = 1'b1;
      end
    end
  end

  // A new beat may enter whenever the output register is empty or being drained this cycle.
  always_comb begin
    in_ready_c = '0;
    if (state_q == StRun) begin
      in_ready_c[sel_q] = !out_valid_q || bus.out_ready;
    end
  end

  assign xfer      = (state_q == StRun) && sel_valid && (!out_valid_q || bus.out_ready);
  assign beat_wrap = (beat_cnt_q == cur_beats - CNT_W'(1));
  assign job_last  = beat_wrap && !has_next && (pix_cnt_q == pixels_q - 32'd1);
  assign cfg_bad   = (cfg_n_inputs < 8'd2) || (32'(cfg_n_inputs) > N_IN) ||
                     (cfg_pixels == 32'd0) || (cfg_nz == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      pixels_q    <= '0;
      pix_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      for (int unsigned i = 0; i < N_IN; i++) beats_q[i] <= '0;
    end else begin
      done_q <= 1'b0;

      // Reload wins over drain so back-to-back beats keep out_valid high.
      if (xfer) begin
        out_data_q  <= sel_data;
        out_src_q   <= 8'(sel_q);
        out_last_q  <= job_last;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_q        <= cfg_n_inputs;
            pixels_q   <= cfg_pixels;
            sel_q      <= cfg_first;
            beat_cnt_q <= '0;
            pix_cnt_q  <= '0;
            busy_q     <= 1'b1;
            for (int unsigned i = 0; i < N_IN; i++) beats_q[i] <= cfg_beats[i*CNT_W +: CNT_W];
            if (cfg_bad) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q   <= 1'b0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (xfer) begin
            if (beat_wrap) begin
              beat_cnt_q <= '0;
              if (has_next) begin
                sel_q <= next_idx;
              end else begin
                sel_q     <= first_idx;
                pix_cnt_q <= pix_cnt_q + 32'd1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            if (job_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_valid_q && bus.out_ready && out_last_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_cfg       = err_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_concat_n_unit.sv
// Bench for concat_n_unit: table of directed jobs plus randomized jobs, each checked against a
// reference stream built by nested pixel/input/beat loops, with hand sequences for reset
// mid-job and start-while-busy.
module tb_concat_n_unit;
  localparam int unsigned BUS_W = 128;
  localparam int unsigned N_IN  = 4;
  localparam int unsigned CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            cfg_n_inputs;
  logic [31:0]           cfg_pixels;
  logic [N_IN*CNT_W-1:0] cfg_beats;
  logic                  start, busy, done, err_cfg;

  always #5 clk = ~clk;

  concat_n_unit_if #(.BUS_W(BUS_W), .N_IN(N_IN)) bus ();

  concat_n_unit #(.BUS_W(BUS_W), .N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_n_inputs (cfg_n_inputs),
    .cfg_pixels   (cfg_pixels),
    .cfg_beats    (cfg_beats),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err_cfg      (err_cfg),
    .bus          (bus)
  );

  typedef struct packed {
    logic [7:0]  n;
    logic [31:0] pixels;
    logic [63:0] beats;
    logic        bp;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   src;
    logic         last;
  } beat_t;

  int          n_chk = 0;
  int          n_pass = 0;
  beat_t       exp_q[$];
  logic [127:0] lane_mem [4][256];
  int          lane_len [4];
  int          ptr [4];
  logic [7:0]  src_log [32];
  int          got;
  vec_t        tbl [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_err"}, err_cfg, 0);
    check({name, "_ovalid"}, bus.out_valid, 0);
    check({name, "_olast"}, bus.out_last, 0);
    check({name, "_odata"}, bus.out_data, 0);
    check({name, "_osrc"}, bus.out_src, 0);
    check({name, "_iready"}, bus.in_ready, 0);
  endtask

  // Reference stream: pixel-major, then input index, then beat within the input.
  task automatic build_model(input vec_t v);
    int    bi;
    beat_t t;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      lane_len[i] = 0;
      ptr[i] = 0;
      for (int k = 0; k < 256; k++) lane_mem[i][k] = {$urandom, $urandom, $urandom, $urandom};
    end
    if (!v.exp_err) begin
      for (int p = 0; p < int'(v.pixels); p++)
        for (int i = 0; i < int'(v.n); i++) begin
          bi = int'(v.beats[i*16 +: 16]);
          for (int b = 0; b < bi; b++) begin
            exp_q.push_back({lane_mem[i][lane_len[i]], 8'(i), 1'b0});
            lane_len[i]++;
          end
        end
      t = exp_q[exp_q.size()-1];
      t.last = 1'b1;
      exp_q[exp_q.size()-1] = t;
    end
  endtask

  // Called at posedge+1. abort_after>0: reset after that many output beats.
  // restart_at>=0: pulse start with a different config on that cycle.
  task automatic run_job(input vec_t v, input int abort_after, input int restart_at);
    int    cyc, done_cnt, done_cyc, last_hs_cyc, viol;
    bit    stall_prev, err_at_done, finished;
    beat_t held, e;
    build_model(v);
    cyc = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -100; viol = 0;
    stall_prev = 0; err_at_done = 0; finished = 0; got = 0;
    cfg_n_inputs = v.n;
    cfg_pixels   = v.pixels;
    cfg_beats    = v.beats;
    start        = 1'b1;
    while (cyc < 3000 && !finished) begin
      bus.out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (ptr[i] < lane_len[i]) begin
          bus.in_valid[i] = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
          bus.in_data[i*BUS_W +: BUS_W] = lane_mem[i][ptr[i]];
        end else begin
          bus.in_valid[i] = 1'($urandom_range(0, 1));
          bus.in_data[i*BUS_W +: BUS_W] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (cyc == restart_at) begin
        start        = 1'b1;
        cfg_n_inputs = 8'd3;
        cfg_pixels   = 32'd1;
        cfg_beats    = 64'h0001_0001_0001_0001;
      end
      #1;
      if ($countones(bus.in_ready) > 1) viol++;
      if (bus.out_valid && !bus.out_ready && bus.in_ready != '0) viol++;
      for (int i = 0; i < 4; i++) if (bus.in_ready[i] && lane_len[i] == 0) viol++;
      if (v.exp_err && bus.out_valid) viol++;
      if (bus.out_valid && bus.out_ready) begin
        if (got < exp_q.size()) begin
          e = exp_q[got];
          check("beat_data", bus.out_data, e.data);
          check("beat_src", bus.out_src, e.src);
          check("beat_last", bus.out_last, e.last);
        end else viol++;
        if (got < 32) src_log[got] = bus.out_src;
        got++;
        if (bus.out_last) last_hs_cyc = cyc;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_data, bus.out_src, bus.out_last};
      for (int i = 0; i < 4; i++)
        if (bus.in_valid[i] && bus.in_ready[i]) begin
          if (ptr[i] >= lane_len[i]) viol++;
          ptr[i]++;
        end
      if (abort_after > 0 && got >= abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check_reset_state("abort");
        done_cnt = 0;
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cfg_n_inputs = v.n;
      cfg_pixels   = v.pixels;
      cfg_beats    = v.beats;
      cyc++;
      if (stall_prev && (!bus.out_valid || held != {bus.out_data, bus.out_src, bus.out_last}))
        viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        err_at_done = err_cfg;
        finished = 1;
      end
    end
    if (!finished) check("job_timeout", 1, 0);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("done_count", done_cnt, 1);
    check("err_cfg", err_at_done, v.exp_err);
    check("beat_count", got, exp_q.size());
    check("violations", viol, 0);
    check("busy_after", busy, 0);
    if (v.exp_err) begin
      check("err_latency_ok", (done_cyc >= 1 && done_cyc <= 2), 1);
      check("err_held", err_cfg, 1);
    end else begin
      check("done_timing", done_cyc, last_hs_cyc + 1);
    end
  endtask

  initial begin
    vec_t r;
    rst = 1'b1; start = 1'b0;
    cfg_n_inputs = '0; cfg_pixels = '0; cfg_beats = '0;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    tbl[0] = '{n: 8'd2, pixels: 32'd3, beats: {16'd0, 16'd0, 16'd2, 16'd1}, bp: 1'b0, exp_err: 1'b0};
    tbl[1] = '{n: 8'd2, pixels: 32'd3, beats: {16'd0, 16'd0, 16'd2, 16'd1}, bp: 1'b1, exp_err: 1'b0};
    tbl[2] = '{n: 8'd4, pixels: 32'd2, beats: {16'd0, 16'd1, 16'd0, 16'd2}, bp: 1'b0, exp_err: 1'b0};
    tbl[3] = '{n: 8'd1, pixels: 32'd3, beats: {16'd1, 16'd1, 16'd1, 16'd1}, bp: 1'b0, exp_err: 1'b1};
    tbl[4] = '{n: 8'd2, pixels: 32'd0, beats: {16'd1, 16'd1, 16'd1, 16'd1}, bp: 1'b0, exp_err: 1'b1};
    tbl[5] = '{n: 8'd5, pixels: 32'd1, beats: {16'd1, 16'd1, 16'd1, 16'd1}, bp: 1'b0, exp_err: 1'b1};
    tbl[6] = '{n: 8'd2, pixels: 32'd2, beats: {16'd5, 16'd5, 16'd0, 16'd0}, bp: 1'b0, exp_err: 1'b1};
    tbl[7] = '{n: 8'd4, pixels: 32'd2, beats: {16'd3, 16'd1, 16'd1, 16'd1}, bp: 1'b1, exp_err: 1'b0};

    for (int t = 0; t < 8; t++) begin
      run_job(tbl[t], 0, -1);
      if (t == 0) begin
        check("t1_beats", got, 9);
        for (int k = 0; k < 9; k++) check("t1_src", src_log[k], (k % 3 == 0) ? 0 : 1);
      end
      if (t == 2) begin
        check("t3_beats", got, 6);
        for (int k = 0; k < 6; k++) check("t3_src", src_log[k], (k % 3 == 2) ? 2 : 0);
      end
    end

    // Reset after 4 of 9 beats, then a clean rerun of the same job.
    run_job(tbl[0], 4, -1);
    run_job(tbl[0], 0, -1);

    // Start pulse with a different config mid-run is ignored.
    run_job(tbl[0], 0, 3);
    check("t6_beats", got, 9);

    for (int j = 0; j < 25; j++) begin
      r.n = 8'($urandom_range(2, 4));
      r.pixels = 32'($urandom_range(1, 6));
      for (int i = 0; i < 4; i++) r.beats[i*16 +: 16] = 16'($urandom_range(0, 3));
      if (r.beats[15:0] == 16'd0 && r.beats[31:16] == 16'd0) r.beats[15:0] = 16'd1;
      r.bp = 1'($urandom_range(0, 1));
      r.exp_err = 1'b0;
      run_job(r, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
